// File: rtl/arbitro_escrita_banco.sv
// -----------------------------------------------------------------------------
// arbitro_escrita_banco
//
// Write-port arbiter and initialization sequencer for the register bank
// (2^LARGURA_END registers of LARGURA_DADO bits, one write port).
//
// After reset it walks every register address and writes VALOR_INICIAL to
// each. Once that walk finishes, it shares the single write port between
// requester A (ULA writeback) and requester B (memory load writeback). Arbitration
// is round-robin and uses a req/ack handshake. All outputs are registered and
// drive the bank directly. The bank commits on the edge after they change.
//
// Optional feature (macro ARB_R0_ZERO_EN):
//   defined   -> a grant targeting register 0 still pulses Ack, but RegWrite
//                stays low, so R0 keeps its init value (hardwired zero).
//   undefined -> register 0 is an ordinary register.
//
// Ports:
//   Clock        in   single clock, all state on posedge
//   Reset        in   synchronous, active-high reset
//   ReqA/ReqB    in   write request, held until the matching Ack is seen
//   RegA/RegB    in   destination register, stable while Req is high
//   DadoA/DadoB  in   write data, stable while Req is high
//   AckA/AckB    out  one-cycle grant pulse
//   RegWrite     out  bank write enable
//   RegEscr      out  bank write address
//   DadoEscr     out  bank write data
//   Pronto       out  init sequence finished, requests are being serviced
//   Prioridade   out  round-robin pointer (0 = A preferred, 1 = B preferred)
// -----------------------------------------------------------------------------
module arbitro_escrita_banco #(
  parameter int unsigned                 LARGURA_DADO  = 8,
  parameter int unsigned                 LARGURA_END   = 3,
  parameter logic [LARGURA_DADO-1:0]     VALOR_INICIAL = 8'h00
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ReqA,
  input  logic [LARGURA_END-1:0]  RegA,
  input  logic [LARGURA_DADO-1:0] DadoA,
  output logic                    AckA,
  input  logic                    ReqB,
  input  logic [LARGURA_END-1:0]  RegB,
  input  logic [LARGURA_DADO-1:0] DadoB,
  output logic                    AckB,
  output logic                    RegWrite,
  output logic [LARGURA_END-1:0]  RegEscr,
  output logic [LARGURA_DADO-1:0] DadoEscr,
  output logic                    Pronto,
  output logic                    Prioridade
);

  typedef enum logic {
    INICIALIZA = 1'b0,
    ATIVO      = 1'b1
  } estado_t;

  estado_t                 estado, estado_next;
  logic [LARGURA_END-1:0]  cont, cont_next;
  logic                    reg_write_next;
  logic [LARGURA_END-1:0]  reg_escr_next;
  logic [LARGURA_DADO-1:0] dado_escr_next;
  logic                    ack_a_next, ack_b_next;
  logic                    pronto_next;
  logic                    prioridade_next;

  // A requester whose Ack is currently high is the one that was just served.
  // Its Req is still up on this edge, so it must not be counted again.
  logic elegivel_a, elegivel_b;
  logic concede_a, concede_b;

  assign elegivel_a = ReqA && !AckA;
  assign elegivel_b = ReqB && !AckB;

  // Both eligible: Prioridade picks the winner. Otherwise, grant whichever one is eligible.
  assign concede_a = elegivel_a && (!elegivel_b || !Prioridade);
  assign concede_b = elegivel_b && (!elegivel_a ||  Prioridade);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    estado_next     = estado;
    cont_next       = cont;
    reg_write_next  = 1'b0;
    reg_escr_next   = RegEscr;
    dado_escr_next  = DadoEscr;
    ack_a_next      = 1'b0;
    ack_b_next      = 1'b0;
    pronto_next     = Pronto;
    prioridade_next = Prioridade;

    unique case (estado)
      INICIALIZA: begin
        // Requests are ignored here. A pending requester simply keeps Req high
        // until the walk is over.
        reg_write_next = 1'b1;
        reg_escr_next  = cont;
        dado_escr_next = VALOR_INICIAL;
        cont_next      = cont + 1'b1;
        if (cont == '1) begin
          estado_next = ATIVO;
          pronto_next = 1'b1;
        end
      end

      ATIVO: begin
        if (concede_a) begin
          ack_a_next      = 1'b1;
          reg_write_next  = 1'b1;
          reg_escr_next   = RegA;
          dado_escr_next  = DadoA;
          prioridade_next = 1'b1;
        end else if (concede_b) begin
          ack_b_next      = 1'b1;
          reg_write_next  = 1'b1;
          reg_escr_next   = RegB;
          dado_escr_next  = DadoB;
          prioridade_next = 1'b0;
        end
`ifdef ARB_R0_ZERO_EN
        // R0 acts as hardwired zero. The grant still completes the handshake,
        // but the bank never sees the write.
        if (reg_escr_next == '0) begin
          reg_write_next = 1'b0;
        end
`endif
      end

      default: begin
        estado_next = INICIALIZA;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from values sampled before the edge.
    if (Reset) begin
      estado     <= INICIALIZA;
      cont       <= '0;
      RegWrite   <= 1'b0;
      RegEscr    <= '0;
      DadoEscr   <= '0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      Pronto     <= 1'b0;
      Prioridade <= 1'b0;
    end else begin
      estado     <= estado_next;
      cont       <= cont_next;
      RegWrite   <= reg_write_next;
      RegEscr    <= reg_escr_next;
      DadoEscr   <= dado_escr_next;
      AckA       <= ack_a_next;
      AckB       <= ack_b_next;
      Pronto     <= pronto_next;
      Prioridade <= prioridade_next;
    end
  end

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// -----------------------------------------------------------------------------
// tb_arbitro_escrita_banco
//
// Directed bench for arbitro_escrita_banco. A small behavioural register bank
// commits whatever the arbiter drives, so stored values can be checked as
// well as the port activity. Stimulus is changed 1 time unit after each
// rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_arbitro_escrita_banco;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ReqA, ReqB;
  logic [2:0] RegA, RegB;
  logic [7:0] DadoA, DadoB;
  logic       AckA, AckB;
  logic       RegWrite;
  logic [2:0] RegEscr;
  logic [7:0] DadoEscr;
  logic       Pronto;
  logic       Prioridade;

  int errors = 0;
  int checks = 0;

  logic [7:0] banco [8];

  arbitro_escrita_banco dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqA       (ReqA),
    .RegA       (RegA),
    .DadoA      (DadoA),
    .AckA       (AckA),
    .ReqB       (ReqB),
    .RegB       (RegB),
    .DadoB      (DadoB),
    .AckB       (AckB),
    .RegWrite   (RegWrite),
    .RegEscr    (RegEscr),
    .DadoEscr   (DadoEscr),
    .Pronto     (Pronto),
    .Prioridade (Prioridade)
  );

  always #5 Clock = ~Clock;

  // Bank model: commits on the edge after the arbiter drives RegWrite.
  always @(posedge Clock) begin
    if (RegWrite) banco[RegEscr] <= DadoEscr;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " RegWrite"},   {15'd0, RegWrite},   16'd0);
    check({tag, " RegEscr"},    {13'd0, RegEscr},    16'd0);
    check({tag, " DadoEscr"},   {8'd0, DadoEscr},    16'd0);
    check({tag, " AckA"},       {15'd0, AckA},       16'd0);
    check({tag, " AckB"},       {15'd0, AckB},       16'd0);
    check({tag, " Pronto"},     {15'd0, Pronto},     16'd0);
    check({tag, " Prioridade"}, {15'd0, Prioridade}, 16'd0);
  endtask

  // Eight init edges: addresses 0..7 with data 00, Pronto only on the last.
  task automatic check_init(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, " RegWrite"}, {15'd0, RegWrite}, 16'd1);
      check({tag, " RegEscr"},  {13'd0, RegEscr},  16'(i));
      check({tag, " DadoEscr"}, {8'd0, DadoEscr},  16'h00);
      check({tag, " AckA"},     {15'd0, AckA},     16'd0);
      check({tag, " AckB"},     {15'd0, AckB},     16'd0);
      check({tag, " Pronto"},   {15'd0, Pronto},   (i == 7) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    Reset = 1'b1;
    ReqA = 1'b0; RegA = '0; DadoA = '0;
    ReqB = 1'b0; RegB = '0; DadoB = '0;

    // Two reset edges.
    tick();
    tick();
    check_idle_reset("reset");

    // Release reset with ReqA already held. It must be ignored during init.
    Reset = 1'b0;
    ReqA = 1'b1; RegA = 3'd3; DadoA = 8'h5A;
    check_init("init");

    // E9: A granted. Prioridade moves to B.
    tick();
    check("grantA AckA",     {15'd0, AckA},       16'd1);
    check("grantA AckB",     {15'd0, AckB},       16'd0);
    check("grantA RegWrite", {15'd0, RegWrite},   16'd1);
    check("grantA RegEscr",  {13'd0, RegEscr},    16'd3);
    check("grantA DadoEscr", {8'd0, DadoEscr},    16'h5A);
    check("grantA prio",     {15'd0, Prioridade}, 16'd1);

    // E10: ReqA still high, but AckA is high, so there is no second grant.
    tick();
    check("ackcyc AckA",     {15'd0, AckA},     16'd0);
    check("ackcyc RegWrite", {15'd0, RegWrite}, 16'd0);
    check("ackcyc RegEscr",  {13'd0, RegEscr},  16'd3);
    check("bank R3",         {8'd0, banco[3]},  16'h5A);
    ReqA = 1'b0;

    // Same destination R5, Prioridade=1: B goes first, A second. A wins.
    ReqA = 1'b1; RegA = 3'd5; DadoA = 8'h11;
    ReqB = 1'b1; RegB = 3'd5; DadoB = 8'h22;
    tick();
    check("same1 AckB",     {15'd0, AckB},       16'd1);
    check("same1 AckA",     {15'd0, AckA},       16'd0);
    check("same1 DadoEscr", {8'd0, DadoEscr},    16'h22);
    check("same1 prio",     {15'd0, Prioridade}, 16'd0);
    tick();
    check("same2 AckA",     {15'd0, AckA},       16'd1);
    check("same2 AckB",     {15'd0, AckB},       16'd0);
    check("same2 RegWrite", {15'd0, RegWrite},   16'd1);
    check("same2 DadoEscr", {8'd0, DadoEscr},    16'h11);
    check("same2 prio",     {15'd0, Prioridade}, 16'd1);
    ReqB = 1'b0;
    tick();
    check("same3 RegWrite", {15'd0, RegWrite},   16'd0);
    check("bank R5",        {8'd0, banco[5]},    16'h11);
    ReqA = 1'b0;

    // Lone B grant brings Prioridade back to 0.
    ReqB = 1'b1; RegB = 3'd1; DadoB = 8'h33;
    tick();
    check("loneB AckB",    {15'd0, AckB},       16'd1);
    check("loneB RegEscr", {13'd0, RegEscr},    16'd1);
    check("loneB prio",    {15'd0, Prioridade}, 16'd0);
    tick();
    check("loneB idle",    {15'd0, RegWrite},   16'd0);
    ReqB = 1'b0;

    // Both held continuously: A,B,A,B with RegWrite always 1.
    ReqA = 1'b1; RegA = 3'd2; DadoA = 8'hA0;
    ReqB = 1'b1; RegB = 3'd4; DadoB = 8'hB0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt AckA",     {15'd0, AckA},       (k % 2 == 0) ? 16'd1 : 16'd0);
      check("alt AckB",     {15'd0, AckB},       (k % 2 == 1) ? 16'd1 : 16'd0);
      check("alt RegWrite", {15'd0, RegWrite},   16'd1);
      check("alt RegEscr",  {13'd0, RegEscr},    (k % 2 == 0) ? 16'd2 : 16'd4);
      check("alt prio",     {15'd0, Prioridade}, (k % 2 == 0) ? 16'd1 : 16'd0);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    tick();
    check("alt end RegWrite", {15'd0, RegWrite}, 16'd0);

    // One-cycle reset while a B request is pending and not acked.
    ReqB = 1'b1; RegB = 3'd6; DadoB = 8'hC3;
    Reset = 1'b1;
    tick();
    check_idle_reset("midreset");
    Reset = 1'b0;
    check_init("reinit");
    tick();
    check("postinit AckB",     {15'd0, AckB},     16'd1);
    check("postinit RegEscr",  {13'd0, RegEscr},  16'd6);
    check("postinit DadoEscr", {8'd0, DadoEscr},  16'hC3);
    tick();
    ReqB = 1'b0;
    check("postinit idle",     {15'd0, RegWrite}, 16'd0);
    check("bank R6",           {8'd0, banco[6]},  16'hC3);
    check("bank R3 reinit",    {8'd0, banco[3]},  16'h00);

    // Write to register 0.
    ReqA = 1'b1; RegA = 3'd0; DadoA = 8'hFF;
    tick();
    check("r0 AckA", {15'd0, AckA}, 16'd1);
`ifdef ARB_R0_ZERO_EN
    check("r0 RegWrite", {15'd0, RegWrite}, 16'd0);
`else
    check("r0 RegWrite", {15'd0, RegWrite}, 16'd1);
`endif
    tick();
    ReqA = 1'b0;
`ifdef ARB_R0_ZERO_EN
    check("bank R0", {8'd0, banco[0]}, 16'h00);
`else
    check("bank R0", {8'd0, banco[0]}, 16'hFF);
`endif

    // Reset held high: outputs stay at reset values even with requests.
    ReqA = 1'b1; ReqB = 1'b1;
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle_reset("hold");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
